// File: rtl/std_dev_sched.sv
// std_dev_sched: round-robin shared window standard-deviation engine.
// Computes floor(sqrt(576*sq_sum - sum*sum)) with one multiplier and a
// 16-step digit-by-digit square root, tagging the result with the requester id.
// Optional macro STD_DEV_CLAMP_EN: clamp a negative variance to zero instead of
// letting the 32-bit subtraction wrap.
module std_dev_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_sum,
    input  logic [NUM_REQ*32-1:0] req_sq_sum,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_std_dev,
    output logic [ID_W-1:0]       out_id,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, MULT, SQRT, DONE} state_t;

    localparam int unsigned N = NUM_REQ;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [31:0]     sum_q, sum_d;
    logic [31:0]     sq_q, sq_d;
    logic [31:0]     var_q, var_d;
    logic [17:0]     rem_q, rem_d;
    logic [15:0]     root_q, root_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [15:0]     std_q, std_d;
    logic [ID_W-1:0] oid_q, oid_d;

    logic [31:0]     sum_arr [NUM_REQ];
    logic [31:0]     sq_arr  [NUM_REQ];
    logic            found;
    logic [ID_W-1:0] gnt;
    logic [ID_W-1:0] idx_w;
    int unsigned     idx;
    logic [31:0]     term;
    logic [31:0]     prod;
    logic [19:0]     rem_shift;
    logic [19:0]     trial;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign sum_arr[g] = req_sum[32*g +: 32];
        assign sq_arr[g]  = req_sq_sum[32*g +: 32];
    end

    // Round-robin search: first valid requester at or above the pointer, with wrap.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        idx_w = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= N) idx = idx - N;
            idx_w = ID_W'(idx);
            if (!found && req_valid[idx_w]) begin
                found = 1'b1;
                gnt   = idx_w;
            end
        end
    end

    // Next-state, datapath and handshake outputs.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        sum_d     = sum_q;
        sq_d      = sq_q;
        var_d     = var_q;
        rem_d     = rem_q;
        root_d    = root_q;
        cnt_d     = cnt_q;
        std_d     = std_q;
        oid_d     = oid_q;
        req_ready = '0;
        // 576*sq_sum mod 2^32 equals {sq[22:0],9'd0} + {sq[25:0],6'd0}.
        term      = sq_q * 32'd576;
        prod      = sum_q * sum_q;
        rem_shift = {rem_q, var_q[31:30]};
        trial     = {2'b00, root_q, 2'b01};
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[gnt] = 1'b1;
                    id_d    = gnt;
                    sum_d   = sum_arr[gnt];
                    sq_d    = sq_arr[gnt];
                    ptr_d   = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + ID_W'(1);
                    state_d = MULT;
                end
            end
            MULT: begin
`ifdef STD_DEV_CLAMP_EN
                var_d = (prod > term) ? '0 : term - prod;
`else
                var_d = term - prod;
`endif
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = 4'd15;
                state_d = SQRT;
            end
            SQRT: begin
                var_d = {var_q[29:0], 2'b00};
                if (rem_shift >= trial) begin
                    rem_d  = 18'(rem_shift - trial);
                    root_d = {root_q[14:0], 1'b1};
                end else begin
                    rem_d  = rem_shift[17:0];
                    root_d = {root_q[14:0], 1'b0};
                end
                if (cnt_q == 4'd0) begin
                    std_d   = root_d;
                    oid_d   = id_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            sum_q   <= '0;
            sq_q    <= '0;
            var_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            std_q   <= '0;
            oid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            sq_q    <= sq_d;
            var_q   <= var_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
            std_q   <= std_d;
            oid_q   <= oid_d;
        end
    end

    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign out_std_dev = {16'd0, std_q};
    assign out_id      = oid_q;

endmodule
